// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD command sequencer: FSM states, command
// opcodes and the single-byte error reply.
package gcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    SEND,
    ERR
  } seqStateT;

  localparam logic [7:0] OP_LOAD_A = 8'h01;
  localparam logic [7:0] OP_LOAD_B = 8'h02;
  localparam logic [7:0] OP_RUN    = 8'h03;
  localparam logic [7:0] OP_STATUS = 8'h04;
  localparam logic [7:0] ERR_CODE  = 8'hEE;

endpackage

// File: rtl/gcd_tx_serializer.sv
// Byte serializer: captures up to WIDTH/8 bytes (right-aligned in loadData)
// and streams them MSB first over a valid/ready handshake.
module gcd_tx_serializer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH / 8 + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] loadData,
  input  logic [CNT_W-1:0] loadCount,
  input  logic             txReady,
  output logic [7:0]       txData,
  output logic             txValid,
  output logic             lastXfer
);

  localparam int NBYTES = WIDTH / 8;

  logic [WIDTH-1:0] shiftReg;
  logic [CNT_W-1:0] remaining;

  // Left-align the payload on load so the first byte is always the top byte;
  // shift out one byte per accepted transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shiftReg  <= '0;
      remaining <= '0;
    end else if (load) begin
      shiftReg  <= loadData << (8 * (NBYTES - int'(loadCount)));
      remaining <= loadCount;
    end else if (txValid && txReady) begin
      shiftReg  <= shiftReg << 8;
      remaining <= remaining - CNT_W'(1);
    end
  end

  assign txData   = shiftReg[WIDTH-1 -: 8];
  assign txValid  = (remaining != '0);
  assign lastXfer = txValid && txReady && (remaining == CNT_W'(1));

endmodule

// File: rtl/gcd_command_sequencer.sv
// UART-style command front end for a GCD engine: loads operands byte-wise,
// launches the engine (or short-circuits zero operands), and returns the
// result, a status byte or an error code through a shared serializer.
module gcd_command_sequencer
  import gcd_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 120000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [WIDTH-1:0] gcd_a,
  output logic [WIDTH-1:0] gcd_b,
  output logic             gcd_start,
  input  logic             gcd_done,
  input  logic [WIDTH-1:0] gcd_result,
  output logic             busy
);

  localparam int NBYTES = WIDTH / 8;
  localparam int CNT_W  = $clog2(NBYTES + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  seqStateT         state;
  seqStateT         stateNext;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             aLoaded;
  logic             bLoaded;
  logic             timeoutFlag;
  logic             overrunFlag;
  logic             loadTargetB;
  logic             statusSend;
  logic [CNT_W-1:0] byteCnt;
  logic [WIDTH-1:0] loadShift;
  logic [WIDTH-1:0] loadShiftNext;
  logic [TO_W-1:0]  timeoutCnt;

  logic             serLoad;
  logic [WIDTH-1:0] serData;
  logic [CNT_W-1:0] serCount;
  logic             serLast;
  logic             startLoad;
  logic             shiftIn;
  logic             commit;
  logic             abortLoad;
  logic             rxDrop;
  logic             clearStatus;
  logic [7:0]       statusByte;

  assign loadShiftNext = (loadShift << 8) | WIDTH'(rx_data);
  assign statusByte    = {4'b0000, bLoaded, aLoaded, timeoutFlag, overrunFlag};
  assign rxDrop        = rx_valid && (state inside {START, WAIT, SEND, ERR});
  assign clearStatus   = (state == SEND) && statusSend && serLast;

  // Next-state decode and the one-cycle control strobes for the datapath.
  always_comb begin
    stateNext = state;
    serLoad   = 1'b0;
    serData   = '0;
    serCount  = '0;
    startLoad = 1'b0;
    shiftIn   = 1'b0;
    commit    = 1'b0;
    abortLoad = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            OP_LOAD_A, OP_LOAD_B: begin
              startLoad = 1'b1;
              stateNext = LOAD;
            end
            OP_RUN: begin
              if (!aLoaded || !bLoaded) begin
                serLoad   = 1'b1;
                serData   = WIDTH'(ERR_CODE);
                serCount  = CNT_W'(1);
                stateNext = ERR;
              end else if (opA == '0 || opB == '0) begin
                // gcd(x,0)=x, and gcd(0,0) is reported as 0.
                serLoad   = 1'b1;
                serData   = opA | opB;
                serCount  = CNT_W'(NBYTES);
                stateNext = SEND;
              end else begin
                stateNext = START;
              end
            end
            OP_STATUS: begin
              serLoad   = 1'b1;
              serData   = WIDTH'(statusByte);
              serCount  = CNT_W'(1);
              stateNext = SEND;
            end
            default: begin
              serLoad   = 1'b1;
              serData   = WIDTH'(ERR_CODE);
              serCount  = CNT_W'(1);
              stateNext = ERR;
            end
          endcase
        end
      end
      LOAD: begin
        if (rx_valid) begin
          shiftIn = 1'b1;
          if (byteCnt == CNT_W'(NBYTES - 1)) begin
            commit    = 1'b1;
            stateNext = IDLE;
          end
        end else if (timeoutCnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          abortLoad = 1'b1;
          stateNext = IDLE;
        end
      end
      START: stateNext = WAIT;
      WAIT: begin
        if (gcd_done) begin
          serLoad   = 1'b1;
          serData   = gcd_result;
          serCount  = CNT_W'(NBYTES);
          stateNext = SEND;
        end
      end
      SEND, ERR: begin
        if (serLast) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // Operand assembly: byte counter, shift register and inter-byte timer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      loadTargetB <= 1'b0;
      byteCnt     <= '0;
      loadShift   <= '0;
      timeoutCnt  <= '0;
    end else if (startLoad) begin
      loadTargetB <= (rx_data == OP_LOAD_B);
      byteCnt     <= '0;
      loadShift   <= '0;
      timeoutCnt  <= '0;
    end else if (shiftIn) begin
      loadShift   <= loadShiftNext;
      byteCnt     <= byteCnt + CNT_W'(1);
      timeoutCnt  <= '0;
    end else if (state == LOAD) begin
      timeoutCnt  <= timeoutCnt + TO_W'(1);
    end
  end

  // Holding registers change only on a complete load, never on abort or RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opA     <= '0;
      opB     <= '0;
      aLoaded <= 1'b0;
      bLoaded <= 1'b0;
    end else if (commit) begin
      if (loadTargetB) begin
        opB     <= loadShiftNext;
        bLoaded <= 1'b1;
      end else begin
        opA     <= loadShiftNext;
        aLoaded <= 1'b1;
      end
    end
  end

  // Sticky error flags; a new event in the clearing cycle wins over the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timeoutFlag <= 1'b0;
      overrunFlag <= 1'b0;
      statusSend  <= 1'b0;
    end else begin
      if (abortLoad)        timeoutFlag <= 1'b1;
      else if (clearStatus) timeoutFlag <= 1'b0;
      if (rxDrop)           overrunFlag <= 1'b1;
      else if (clearStatus) overrunFlag <= 1'b0;
      if (state == IDLE && rx_valid) statusSend <= (rx_data == OP_STATUS);
    end
  end

  gcd_tx_serializer #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) txSer (
    .clk       (clk),
    .reset     (reset),
    .load      (serLoad),
    .loadData  (serData),
    .loadCount (serCount),
    .txReady   (tx_ready),
    .txData    (tx_data),
    .txValid   (tx_valid),
    .lastXfer  (serLast)
  );

  assign gcd_a     = opA;
  assign gcd_b     = opB;
  assign gcd_start = (state == START);
  assign busy      = (state != IDLE);

endmodule
